// File: rtl/vector_pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vector_pe_pkg
//  Brief    : Shared constants and helpers for the vector_pe dot-product PE:
//             ctl bit positions, default parameter values, ceil-log2 helper.
//  Revision : 1.0 - initial release
// ============================================================================
package vector_pe_pkg;

    // Bit positions inside the 2-bit ctl beat tag
    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    // Default build parameters
    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    // Ceil-log2; returns 0 for an argument of 1 so a single lane needs no tree
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage : vector_pe_pkg
`default_nettype wire

// File: rtl/vector_pe_tree.sv
`default_nettype none
// ============================================================================
//  Module   : vector_pe_tree
//  Brief    : Combinational balanced adder tree summing LANES signed operands
//             of IN_W bits into a lossless IN_W+log2(LANES)-bit sum.
//             The parent registers the output.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_pe_tree
    import vector_pe_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int IN_W  = 2 * DEF_DATA_W
) (
    input  logic [LANES*IN_W-1:0]                 operands,
    output logic signed [IN_W+clog2(LANES)-1:0]   sum
);

    localparam int DEPTH = clog2(LANES);
    localparam int OUT_W = IN_W + DEPTH;

    // Level 0 holds the sign-extended leaves; each later level halves the
    // node count. Every node is kept at full output width so no level can
    // overflow regardless of operand values.
    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        localparam int NODES = LANES >> l;
        logic signed [OUT_W-1:0] w_node [NODES];

        for (genvar i = 0; i < NODES; i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign w_node[i] = OUT_W'($signed(operands[i*IN_W +: IN_W]));
            end else begin : g_add
                assign w_node[i] = g_lvl[l-1].w_node[2*i] + g_lvl[l-1].w_node[2*i+1];
            end
        end
    end

    assign sum = g_lvl[DEPTH].w_node[0];

endmodule : vector_pe_tree
`default_nettype wire

// File: rtl/vector_pe.sv
`default_nettype none
// ============================================================================
//  Module   : vector_pe
//  Brief    : Multi-lane signed dot-product processing element. Per accepted
//             beat: S1 registers lane products, S2 registers the lane-tree
//             sum, S3 loads/accumulates and publishes the vector result on
//             the last beat. Valid/ready handshake on both sides.
//             Optional macro VECTOR_PE_SAT_EN: saturating accumulator with
//             sticky saturation until the next first-beat load; otherwise
//             the accumulator wraps modulo 2^ACC_W.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_pe
    import vector_pe_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*DATA_W-1:0]   neuron,
    input  logic [LANES*DATA_W-1:0]   weight,
    input  logic [1:0]                ctl,
    input  logic                      vld_i,
    output logic                      rdy_o,
    output logic signed [ACC_W-1:0]   result,
    output logic                      vld_o,
    input  logic                      rdy_i
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + clog2(LANES);

    // Pipeline state
    logic                     r_s1_vld;
    logic [1:0]               r_s1_ctl;
    logic [LANES*PROD_W-1:0]  r_prod;
    logic                     r_s2_vld;
    logic [1:0]               r_s2_ctl;
    logic signed [SUM_W-1:0]  r_s2_sum;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_result;
    logic                     r_vld_o;

    logic [LANES*PROD_W-1:0]  w_prod;
    logic signed [SUM_W-1:0]  w_tree_sum;
    logic                     w_stall;
    logic                     w_accept;
    logic                     w_s3_fire;
    logic signed [ACC_W-1:0]  w_acc_next;

    // Freeze only when an unconsumed result would be overwritten by the
    // next last beat; non-last beats may keep flowing into the accumulator.
    assign w_stall   = r_vld_o && !rdy_i && r_s2_vld && r_s2_ctl[CTL_LAST];
    assign rdy_o     = !w_stall;
    assign w_accept  = vld_i && !w_stall;
    assign w_s3_fire = r_s2_vld && !w_stall;

    // Per-lane full-precision signed multipliers
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DATA_W-1:0] w_n;
        logic signed [DATA_W-1:0] w_w;
        logic signed [PROD_W-1:0] w_p;
        assign w_n = neuron[i*DATA_W +: DATA_W];
        assign w_w = weight[i*DATA_W +: DATA_W];
        assign w_p = w_n * w_w;
        assign w_prod[i*PROD_W +: PROD_W] = w_p;
    end

    vector_pe_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W)
    ) u_tree (
        .operands (r_prod),
        .sum      (w_tree_sum)
    );

    // S1: capture products and beat tag for accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_ctl <= '0;
            r_prod   <= '0;
        end else if (!w_stall) begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_ctl <= ctl;
                r_prod   <= w_prod;
            end
        end
    end

    // S2: register the lane-tree sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_ctl <= '0;
            r_s2_sum <= '0;
        end else if (!w_stall) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_ctl <= r_s1_ctl;
                r_s2_sum <= w_tree_sum;
            end
        end
    end

`ifdef VECTOR_PE_SAT_EN
    // One guard bit above the wider of accumulator and beat sum keeps the
    // raw update exact so it can be clamped afterwards.
    localparam int EXT_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
    localparam logic signed [EXT_W-1:0] c_acc_max = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] c_acc_min = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic                     r_sat;
    logic                     w_sat_next;
    logic signed [EXT_W-1:0]  w_raw;

    // S3 next value: exact update, clamp, sticky once clamped
    always_comb begin
        w_raw      = EXT_W'(r_s2_sum);
        w_acc_next = r_acc;
        w_sat_next = r_sat;
        if (!r_s2_ctl[CTL_FIRST]) begin
            w_raw = EXT_W'(r_acc) + EXT_W'(r_s2_sum);
        end
        if (!r_s2_ctl[CTL_FIRST] && r_sat) begin
            w_acc_next = r_acc;
            w_sat_next = 1'b1;
        end else if (w_raw > c_acc_max) begin
            w_acc_next = c_acc_max[ACC_W-1:0];
            w_sat_next = 1'b1;
        end else if (w_raw < c_acc_min) begin
            w_acc_next = c_acc_min[ACC_W-1:0];
            w_sat_next = 1'b1;
        end else begin
            w_acc_next = w_raw[ACC_W-1:0];
            w_sat_next = 1'b0;
        end
    end

    // Sticky saturation flag, cleared by reset or a first-beat load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_s3_fire) begin
            r_sat <= w_sat_next;
        end
    end
`else
    logic signed [ACC_W-1:0] w_sum_acc;

    // Beat sum resized to the accumulator; excess bits wrap by design
    assign w_sum_acc = ACC_W'(r_s2_sum);

    // S3 next value: load on first beat, else modular add
    always_comb begin
        w_acc_next = r_acc + w_sum_acc;
        if (r_s2_ctl[CTL_FIRST]) begin
            w_acc_next = w_sum_acc;
        end
    end
`endif

    // S3: accumulator update and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_result <= '0;
            r_vld_o  <= 1'b0;
        end else begin
            if (w_s3_fire) begin
                r_acc <= w_acc_next;
            end
            if (w_s3_fire && r_s2_ctl[CTL_LAST]) begin
                r_result <= w_acc_next;
                r_vld_o  <= 1'b1;
            end else if (rdy_i) begin
                r_vld_o  <= 1'b0;
            end
        end
    end

    assign result = r_result;
    assign vld_o  = r_vld_o;

endmodule : vector_pe
`default_nettype wire

// File: tb/tb_vector_pe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_pe
//  Brief    : Directed self-checking bench for vector_pe (LANES=4, DATA_W=16,
//             ACC_W=32): basic vector, single-beat vector, back-to-back
//             vectors, output back-pressure, overflow, mid-vector reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vector_pe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [63:0]        neuron;
    logic [63:0]        weight;
    logic [1:0]         ctl;
    logic               vld_i;
    logic               rdy_o;
    logic signed [31:0] result;
    logic               vld_o;
    logic               rdy_i;

    int checks     = 0;
    int failures   = 0;
    int ready_waits = 0;
    logic [31:0] res_q [$];

    vector_pe #(
        .LANES  (4),
        .DATA_W (16),
        .ACC_W  (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .vld_i  (vld_i),
        .rdy_o  (rdy_o),
        .result (result),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i)
    );

    always #5 clk = ~clk;

    // Capture every result handed over downstream
    always @(posedge clk) begin
        if (rst_n && vld_o && rdy_i) res_q.push_back(result);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [63:0] p;
        p[15:0]  = 16'(l0);
        p[31:16] = 16'(l1);
        p[47:32] = 16'(l2);
        p[63:48] = 16'(l3);
        return p;
    endfunction

    // Present one beat and hold it until accepted; returns 1 ns after the
    // accepting edge with vld_i dropped
    task automatic send_beat(input logic [63:0] n, input logic [63:0] w, input logic [1:0] c);
        int waits;
        waits = 0;
        @(negedge clk);
        neuron = n;
        weight = w;
        ctl    = c;
        vld_i  = 1'b1;
        #1;
        while (!rdy_o && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!rdy_o) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=rdy_o_low expected=accept");
        end
        ready_waits += waits;
        @(posedge clk);
        #1;
        vld_i = 1'b0;
    endtask

    task automatic expect_result(input logic [31:0] exp, input string tag);
        int n;
        n = 0;
        while (res_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (res_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=no_result expected=0x%08h", tag, exp);
        end else begin
            chk(tag, res_q.pop_front(), exp);
        end
    endtask

    initial begin
        int exp_v [4];
        int nl [4];
        int wl [4];
        logic [31:0] ovf_exp;

        rst_n  = 1'b0;
        neuron = '0;
        weight = '0;
        ctl    = '0;
        vld_i  = 1'b0;
        rdy_i  = 1'b1;

        // Reset state
        #12;
        chk("reset_result", result, 32'd0);
        chk("reset_vld_o", 32'(vld_o), 32'd0);
        chk("reset_rdy_o", 32'(rdy_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8-beat vector, neuron=1 weight=2 on all lanes -> 64, 3-cycle latency
        for (int b = 0; b < 8; b++) begin
            send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), {b == 7, b == 0});
        end
        chk("lat_after1", 32'(vld_o), 32'd0);
        @(posedge clk); #1;
        chk("lat_after2", 32'(vld_o), 32'd0);
        @(posedge clk); #1;
        chk("lat_after3_vld", 32'(vld_o), 32'd1);
        chk("lat_after3_result", result, 32'd64);
        @(posedge clk); #1;
        chk("lat_consumed", 32'(vld_o), 32'd0);
        expect_result(32'd64, "vec8_result");

        // Single-beat vector {3,-4,5,-6} x 7 -> -14
        send_beat(pack4(3, -4, 5, -6), pack4(7, 7, 7, 7), 2'b11);
        expect_result(32'hFFFF_FFF2, "single_beat");

        // Four back-to-back 32-beat vectors against a bench-computed golden
        ready_waits = 0;
        for (int v = 0; v < 4; v++) begin
            exp_v[v] = 0;
            for (int b = 0; b < 32; b++) begin
                for (int l = 0; l < 4; l++) begin
                    nl[l] = ((v * 37 + b * 11 + l * 5) % 200) - 100;
                    wl[l] = ((v * 13 + b * 7 + l * 3) % 150) - 75;
                    exp_v[v] += nl[l] * wl[l];
                end
                send_beat(pack4(nl[0], nl[1], nl[2], nl[3]),
                          pack4(wl[0], wl[1], wl[2], wl[3]), {b == 31, b == 0});
            end
        end
        chk("b2b_rdy_no_gap", 32'(ready_waits), 32'd0);
        for (int v = 0; v < 4; v++) begin
            expect_result(exp_v[v], $sformatf("b2b_vec%0d", v));
        end

        // Back-pressure: A=16 held, B=96 stalls pipeline, C=-40 after release
        rdy_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), {b == 3, b == 0});
        end
        for (int b = 0; b < 4; b++) begin
            send_beat(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), {b == 3, b == 0});
        end
        @(posedge clk); #1;
        neuron = pack4(-1, -1, -1, -1);
        weight = pack4(5, 5, 5, 5);
        ctl    = 2'b01;
        vld_i  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall_rdy_o_%0d", c), 32'(rdy_o), 32'd0);
            chk($sformatf("stall_vld_o_%0d", c), 32'(vld_o), 32'd1);
            chk($sformatf("stall_result_%0d", c), result, 32'd16);
            @(posedge clk); #1;
        end
        rdy_i = 1'b1;
        send_beat(pack4(-1, -1, -1, -1), pack4(5, 5, 5, 5), 2'b01);
        send_beat(pack4(-1, -1, -1, -1), pack4(5, 5, 5, 5), 2'b10);
        expect_result(32'd16, "stall_vecA");
        expect_result(32'd96, "stall_vecB");
        expect_result(32'hFFFF_FFD8, "stall_vecC");

        // Overflow: four beats of 0x7FFF*0x7FFF on lane 0
`ifdef VECTOR_PE_SAT_EN
        ovf_exp = 32'h7FFF_FFFF;
`else
        ovf_exp = 32'hFFFC_0004;
`endif
        for (int b = 0; b < 4; b++) begin
            send_beat(pack4(32'h7FFF, 0, 0, 0), pack4(32'h7FFF, 0, 0, 0), {b == 3, b == 0});
        end
        expect_result(ovf_exp, "overflow");

        // Mid-vector reset clears outputs at once; next vector is clean
        for (int b = 0; b < 3; b++) begin
            send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), {1'b0, b == 0});
        end
        chk("pre_reset_result", result, ovf_exp);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld_o", 32'(vld_o), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rdy_o", 32'(rdy_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 4; b++) begin
            send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), {b == 3, b == 0});
        end
        expect_result(32'd16, "post_reset_vec");
        repeat (5) @(negedge clk);
        chk("no_extra_results", 32'(res_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vector_pe
`default_nettype wire

// File: doc/vector_pe.md
VECTOR_PE -- requirements
Module: vector_pe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel multiply lanes (power of two, 1..32).
REQ-002 SHALL have parameter DATA_W, default 16, signed operand width per lane.
REQ-003 SHALL have parameter ACC_W, default 32, signed accumulator/result width (>= 2*DATA_W).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port neuron  input  LANES*DATA_W  packed neuron operands; lane 0 in LSBs.
REQ-007 SHALL have port weight  input  LANES*DATA_W  packed weight operands; lane 0 in LSBs.
REQ-008 SHALL have port ctl  input  2  bit0 = first beat of vector, bit1 = last beat of vector.
REQ-009 SHALL have port vld_i  input  1  input beat valid.
REQ-010 SHALL have port rdy_o  output  1  input beat accepted when vld_i && rdy_o.
REQ-011 SHALL have port result  output  ACC_W  signed dot-product result.
REQ-012 SHALL have port vld_o  output  1  result valid.
REQ-013 SHALL have port rdy_i  input  1  downstream accepts result when vld_o && rdy_i.

Function
REQ-014 SHALL compute, per accepted beat, the signed sum over all lanes of neuron[i]*weight[i] (two's complement, 2*DATA_W-bit products, tree width 2*DATA_W+log2(LANES), no loss).
REQ-015 SHALL use a 3-stage pipeline: S1 registered products, S2 registered lane-tree sum, S3 accumulator update.
REQ-016 SHALL, on a beat with ctl[0]=1, load the accumulator with that beat's sum (discarding prior contents); otherwise add the sum to the accumulator.
REQ-017 SHALL, on a beat with ctl[1]=1, present the updated accumulator on result with vld_o=1 exactly 3 cycles after acceptance when unstalled.
REQ-018 SHALL treat ctl=2'b11 as a one-beat vector: result equals that beat's sum.
REQ-019 SHALL ignore ctl and operands on cycles where vld_i && rdy_o is false; bubbles do not alter the accumulator.
REQ-020 SHALL, without ACC_W overflow handling enabled, wrap the accumulator modulo 2^ACC_W.
REQ-021 SHALL hold result and vld_o stable while vld_o && !rdy_i.
REQ-022 SHALL freeze the whole pipeline (stall) while vld_o && !rdy_i and a further last beat would reach S3; rdy_o = 0 during stall.
REQ-023 SHALL, when vld_o && rdy_i coincides with a new result arriving at S3, replace the result with no bubble and keep vld_o=1.
REQ-024 SHALL sustain one beat per cycle and back-to-back vectors (ctl[1] beat followed immediately by ctl[0] beat) with no lost or merged results.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear all pipeline valids, accumulator, result to 0, vld_o to 0; rdy_o SHALL be 1 after reset.
REQ-026 SHALL, on reset mid-vector, discard partial sums; first result after release requires a fresh ctl[0] beat.

Configuration
REQ-027 SHALL, with macro VECTOR_PE_SAT_EN defined, saturate each accumulator update to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and hold saturation until the next ctl[0] load.
REQ-028 SHALL, without VECTOR_PE_SAT_EN, implement wrap-around per REQ-020 with no saturation logic.

Structure
REQ-029 SHALL place ctl bit index constants (CTL_FIRST=0, CTL_LAST=1), default parameter values and a log2 helper in package vector_pe_pkg.
REQ-030 SHALL implement the lane adder tree as sub-module vector_pe_tree (parameters LANES, IN_W), combinational, registered by parent at S2.

Verification
REQ-031 SHALL cover: LANES=4, one vector of 8 beats, all lanes neuron=1, weight=2 -> result=64, vld_o 3 cycles after last beat.
REQ-032 SHALL cover: ctl=2'b11 single beat, neuron lanes {3,-4,5,-6}, weight all 7 -> result=-14.
REQ-033 SHALL cover: 4 back-to-back 32-beat vectors matching golden file -> 4 correct results in order, no gaps in rdy_o.
REQ-034 SHALL cover: rdy_i held 0 for 10 cycles while streaming -> result stable, rdy_o=0 once stalled, no beat lost after release.
REQ-035 SHALL cover: accumulate 0x7FFF*0x7FFF beats past 2^31 -> wraps without VECTOR_PE_SAT_EN, result=0x7FFFFFFF with it.
REQ-036 SHALL cover: rst_n pulsed low mid-vector -> vld_o=0, result=0 immediately; next full vector gives correct result.
